// File: rtl/eth_pkg.sv
// Shared Ethernet constants, deframer state encoding and a byte-wise CRC-32 helper.
package eth_pkg;

    localparam int MAC_OCTETS       = 6;
    localparam int ETHERTYPE_OCTETS = 2;
    localparam int HEADER_OCTETS    = 14;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        ST_PREAMBLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_DROP
    } deframer_state_t;

    // Reflected (LSB-first) CRC-32 update over one byte; the polynomial is bit-reversed here.
    function automatic logic [31:0] crc32_update(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] poly_r;
        logic [31:0] c;
        for (int i = 0; i < 32; i++) poly_r[i] = CRC32_POLY[31-i];
        c = crc ^ {24'd0, data};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide CRC-32 register: combinational next value plus a state register with clear and enable.
module eth_crc32
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        areset,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [31:0] crc,
    output logic [31:0] crc_next
);

    assign crc_next = crc32_update(crc, data);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge areset) begin
        if (areset)      crc <= CRC32_INIT;
        else if (clear)  crc <= CRC32_INIT;
        else if (enable) crc <= crc_next;
    end

endmodule

// File: rtl/eth_deframer.sv
// Ethernet receive deframer: preamble/SFD check, header extraction, payload forwarding.
// Optional FCS check and stripping when ETH_DEFRAMER_FCS_CHECK_EN is defined.
module eth_deframer
    import eth_pkg::*;
#(
    parameter int PREAMBLE_MIN = 7
) (
    input  logic        clk,
    input  logic        areset,
    output logic        in_axis_tready,
    input  logic        in_axis_tvalid,
    input  logic        in_axis_tlast,
    input  logic [7:0]  in_axis_tdata,
    input  logic        out_axis_tready,
    output logic        out_axis_tvalid,
    output logic        out_axis_tlast,
    output logic [7:0]  out_axis_tdata,
    output logic        out_axis_tuser,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac,
    output logic [15:0] ethertype,
    output logic        hdr_valid,
    output logic        frame_drop
);

    localparam int               PRE_W    = $clog2(PREAMBLE_MIN + 1);
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PREAMBLE_MIN);
    localparam logic [3:0]       HDR_LAST = 4'(HEADER_OCTETS - 1);
    localparam int               SHIFT_W  = (HEADER_OCTETS - 1) * 8;
    localparam int               HDR_W    = HEADER_OCTETS * 8;

    deframer_state_t state, state_next;

    logic [PRE_W-1:0]   pre_cnt;
    logic [3:0]         hdr_cnt;
    logic [SHIFT_W-1:0] hdr_shift;
    logic [HDR_W-1:0]   hdr_full;
    logic               in_fire;
    logic               pay_fire;
    logic               hdr_done;
    logic               drop_set;
    logic               emit;
    logic [7:0]         emit_data;

    assign in_axis_tready = (state == ST_PAYLOAD) ? (!out_axis_tvalid || out_axis_tready) : 1'b1;
    assign in_fire        = in_axis_tvalid && in_axis_tready;
    assign pay_fire       = in_fire && (state == ST_PAYLOAD);
    // The 14th header byte is taken straight from the bus so the fields load on its accept edge.
    assign hdr_full       = {hdr_shift, in_axis_tdata};

`ifdef ETH_DEFRAMER_FCS_CHECK_EN
    logic [3:0][7:0] dly;
    logic [2:0]      dly_cnt;
    logic            dly_full;
    logic [31:0]     crc_q;
    logic [31:0]     crc_next;

    eth_crc32 u_crc32 (
        .clk      (clk),
        .areset   (areset),
        .clear    (state == ST_PREAMBLE),
        .enable   (in_fire && (state == ST_HEADER || state == ST_PAYLOAD)),
        .data     (in_axis_tdata),
        .crc      (crc_q),
        .crc_next (crc_next)
    );

    // Payload is held back four bytes so the FCS never reaches the output.
    assign dly_full  = (dly_cnt == 3'd4);
    assign emit      = pay_fire && dly_full;
    assign emit_data = dly[3];

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            dly            <= '0;
            dly_cnt        <= '0;
            out_axis_tuser <= 1'b0;
        end else begin
            if (pay_fire) begin
                dly     <= {dly[2:0], in_axis_tdata};
                dly_cnt <= in_axis_tlast ? 3'd0 : (dly_full ? dly_cnt : dly_cnt + 3'd1);
            end
            if (emit) out_axis_tuser <= in_axis_tlast && (crc_next != CRC32_RESIDUE);
        end
    end
`else
    assign emit           = pay_fire;
    assign emit_data      = in_axis_tdata;
    assign out_axis_tuser = 1'b0;
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) state <= ST_PREAMBLE;
        else        state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        drop_set   = 1'b0;
        hdr_done   = 1'b0;
        case (state)
            ST_PREAMBLE: begin
                if (in_fire) begin
                    if (in_axis_tlast) begin
                        drop_set = 1'b1;
                    end else if (in_axis_tdata == SFD_BYTE && pre_cnt >= PRE_MAX) begin
                        state_next = ST_HEADER;
                    end else if (in_axis_tdata != PREAMBLE_BYTE) begin
                        state_next = ST_DROP;
                        drop_set   = 1'b1;
                    end
                end
            end
            ST_HEADER: begin
                if (in_fire) begin
                    if (in_axis_tlast) begin
                        state_next = ST_PREAMBLE;
                        drop_set   = 1'b1;
                    end else if (hdr_cnt == HDR_LAST) begin
                        state_next = ST_PAYLOAD;
                        hdr_done   = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (in_fire && in_axis_tlast) begin
                    state_next = ST_PREAMBLE;
`ifdef ETH_DEFRAMER_FCS_CHECK_EN
                    drop_set   = !dly_full;
`endif
                end
            end
            ST_DROP: begin
                if (in_fire && in_axis_tlast) state_next = ST_PREAMBLE;
            end
            default: state_next = ST_PREAMBLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            pre_cnt    <= '0;
            hdr_cnt    <= '0;
            hdr_shift  <= '0;
            dst_mac    <= '0;
            src_mac    <= '0;
            ethertype  <= '0;
            hdr_valid  <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            hdr_valid  <= hdr_done;
            frame_drop <= drop_set;
            if (in_fire && state == ST_PREAMBLE) begin
                if (!in_axis_tlast && in_axis_tdata == PREAMBLE_BYTE)
                    pre_cnt <= (pre_cnt == PRE_MAX) ? pre_cnt : pre_cnt + 1'b1;
                else
                    pre_cnt <= '0;
            end
            if (in_fire && state == ST_HEADER) begin
                hdr_shift <= {hdr_shift[SHIFT_W-9:0], in_axis_tdata};
                hdr_cnt   <= (in_axis_tlast || hdr_cnt == HDR_LAST) ? 4'd0 : hdr_cnt + 4'd1;
            end
            if (hdr_done) begin
                dst_mac   <= hdr_full[HDR_W-1 -: MAC_OCTETS*8];
                src_mac   <= hdr_full[HDR_W-MAC_OCTETS*8-1 -: MAC_OCTETS*8];
                ethertype <= hdr_full[ETHERTYPE_OCTETS*8-1:0];
            end
        end
    end

    // Single-beat output register; a new beat only lands when the slot is free or draining.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            out_axis_tvalid <= 1'b0;
            out_axis_tlast  <= 1'b0;
            out_axis_tdata  <= '0;
        end else begin
            if (out_axis_tvalid && out_axis_tready) out_axis_tvalid <= 1'b0;
            if (emit) begin
                out_axis_tvalid <= 1'b1;
                out_axis_tdata  <= emit_data;
                out_axis_tlast  <= in_axis_tlast;
            end
        end
    end

endmodule

// File: doc/eth_deframer.md
# eth_deframer

Receive-side counterpart of the Ethernet framer. Accepts a byte-wide AXI Stream carrying complete Ethernet frames, one frame per packet (tlast on the final byte). Validates preamble and SFD, extracts destination MAC, source MAC and ethertype onto registered side-band outputs, and forwards the payload as a byte-wide AXI Stream. Sits between the PHY/MAC byte receiver and the protocol layers (IPv4/ARP).

## Interface
- PREAMBLE_MIN, 7: minimum number of 0x55 bytes required before the 0xD5 SFD; longer preambles are accepted.
- clk  in  1  single clock for all logic.
- areset  in  1  reset; asynchronous, active-high.
- in_axis_tready  out  1  input handshake.
- in_axis_tvalid  in  1  input handshake.
- in_axis_tlast  in  1  last byte of the frame (FCS byte 3).
- in_axis_tdata  in  8  frame byte.
- out_axis_tready  in  1  payload handshake.
- out_axis_tvalid  out  1  payload handshake.
- out_axis_tlast  out  1  last payload byte.
- out_axis_tdata  out  8  payload byte.
- out_axis_tuser  out  1  on the tlast beat: 1 = FCS error; otherwise 0.
- dst_mac  out  48  first header byte is [47:40].
- src_mac  out  48  same MSB-first order.
- ethertype  out  16  first byte is [15:8].
- hdr_valid  out  1  one-cycle pulse when the header fields are updated.
- frame_drop  out  1  one-cycle pulse when a frame is discarded.

## Operation
- States: PREAMBLE, HEADER, PAYLOAD, DROP.
- PREAMBLE: counts accepted 0x55 bytes, saturating at PREAMBLE_MIN.
  - 0xD5 with count ≥ PREAMBLE_MIN → HEADER.
  - Any other byte, or 0xD5 with count < PREAMBLE_MIN → DROP, and frame_drop pulses.
  - If that byte carries tlast → stay in PREAMBLE, and frame_drop pulses.
- HEADER: a 4-bit counter shifts 14 bytes into dst_mac (6), src_mac (6) and ethertype (2).
  - Fields update atomically one cycle after byte 14 is accepted, with hdr_valid asserted in that same cycle. They hold until the next frame's header completes.
  - tlast during HEADER → PREAMBLE, frame_drop pulses, fields unchanged.
  - After byte 14 → PAYLOAD.
- PAYLOAD: bytes are forwarded. Input tlast → PREAMBLE after the last beat is accepted into the output register.
- DROP: consumes bytes with in_axis_tready = 1 until tlast, then → PREAMBLE.
- in_axis_tready:
  - Always 1 in PREAMBLE, HEADER and DROP.
  - In PAYLOAD, equals (!out_axis_tvalid || out_axis_tready).
- The output register holds one beat. tvalid, tdata and tlast stay stable until accepted.

## Timing
- Reset values:
  - State PREAMBLE.
  - out_axis_tvalid, out_axis_tlast, out_axis_tdata and out_axis_tuser all 0.
  - dst_mac, src_mac and ethertype all 0.
  - hdr_valid and frame_drop both 0.
  - All counters, the CRC register and the delay line cleared.
- Header is fully consumed in 14 accepted beats, with no stalls.
- Payload latency, macro off: out_axis_tvalid rises 1 cycle after the first payload byte is accepted.
- Payload latency, macro on: see Configuration.
- Back-to-back frames: the first preamble byte of frame N+1 may be accepted in the cycle after frame N's tlast is accepted. No idle cycle is required.
- An asserted areset, at any point mid-frame, returns to reset values immediately.
  - Any partial frame in flight when areset asserts is lost; frame_drop does not pulse.
  - After release, bytes of that partial frame arrive without a valid preamble → DROP.

## Configuration
- ETH_DEFRAMER_FCS_CHECK_EN defined:
  - Byte-wise CRC-32 (reflected, poly 0x04C11DB7, init 0xFFFFFFFF) runs over header, payload and FCS.
  - A 4-byte delay line strips the FCS. Payload byte k is emitted only after byte k+4 is accepted; out_axis_tlast marks the byte 4 before input tlast.
  - out_axis_tuser = 1 on that beat if the residue ≠ 0xDEBB20E3.
  - Frames with ≤ 4 post-header bytes emit nothing and pulse frame_drop.
- Macro undefined: no CRC logic. All post-header bytes, FCS included, pass through; out_axis_tlast aligns with input tlast; out_axis_tuser is constant 0.

## Structure
- Shared package eth_pkg:
  - MAC_OCTETS = 6, ETHERTYPE_OCTETS = 2 and HEADER_OCTETS = 14.
  - PREAMBLE_BYTE = 8'h55 and SFD_BYTE = 8'hD5.
  - CRC32_POLY, CRC32_INIT and CRC32_RESIDUE.
  - The deframer state enum typedef.
- One sub-module, eth_crc32: byte-wide combinational next-CRC plus a register with clear and enable. It is instantiated only under the macro and is reusable by a future framer FCS stage.

## Test plan
- 7×0x55, 0xD5, dst 02:00:00:00:00:01, src 02:00:00:00:00:02, ethertype 0x0800, 46-byte payload 0x00..0x2D, valid FCS:
  - hdr_valid pulses once with those field values.
  - 46 payload bytes out, last one tagged tlast, tuser = 0 (macro on).
  - 50 bytes out, FCS included, when the macro is off.
- Same frame with one payload byte flipped, macro on → payload unchanged except that byte; tuser = 1 on the tlast beat.
- 5×0x55 then 0xD5, PREAMBLE_MIN = 7 → frame_drop pulse; no output beats; the next valid frame is received correctly.
- tlast on header byte 9 → frame_drop pulse; dst_mac, src_mac and ethertype keep the previous frame's values; no hdr_valid.
- out_axis_tready toggling 1-0-0-1 throughout payload → in_axis_tready follows the rule in Operation; payload is byte-exact and in order; no beat lost or duplicated.
- areset asserted at payload byte 20, deasserted, then a valid frame sent → all outputs 0 during reset; the subsequent frame is received byte-exact.
